// File: rtl/mc_rq_buf.sv
// Request buffer between the PHOLD engine and the MC port: a FIFO with registered
// issue, almost-full backpressure, MC stall accounting and a write-flush handshake.
module mc_rq_buf #(
    parameter int unsigned RTNCTL_WIDTH = 32,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned AF_SLACK     = 6
) (
    input  logic                      clk,
    input  logic                      i_reset,

    input  logic                      in_vld,
    input  logic [2:0]                in_cmd,
    input  logic [3:0]                in_scmd,
    input  logic [1:0]                in_size,
    input  logic [47:0]               in_vadr,
    input  logic [63:0]               in_data,
    input  logic [RTNCTL_WIDTH-1:0]   in_rtnctl,
    output logic                      in_stall,
    input  logic                      in_flush,
    output logic                      flush_done,

    output logic                      mc_rq_vld,
    output logic [2:0]                mc_rq_cmd,
    output logic [3:0]                mc_rq_scmd,
    output logic [1:0]                mc_rq_size,
    output logic [47:0]               mc_rq_vadr,
    output logic [63:0]               mc_rq_data,
    output logic [RTNCTL_WIDTH-1:0]   mc_rq_rtnctl,
    input  logic                      mc_rq_stall,
    output logic                      mc_rq_flush,
    input  logic                      mc_rs_flush_cmplt,

    output logic [$clog2(DEPTH):0]    occupancy,
    output logic [31:0]               stall_cycles,
    output logic                      overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned EW = 121 + RTNCTL_WIDTH;

    typedef enum logic [2:0] {StIdle, StDrain, StFlush, StWait, StDone} flush_st_e;

    logic [EW-1:0]  mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           full;
    logic           push;
    logic           pop;
    flush_st_e      flush_st;

    assign full      = (count == (AW+1)'(DEPTH));
    assign push      = in_vld && !full;
    assign pop       = (count != '0) && !mc_rq_stall;
    assign occupancy = count;
    assign in_stall  = ((32'(DEPTH) - 32'(count)) <= 32'(AF_SLACK)) || (flush_st != StIdle);

    // Storage is not reset; only the pointers and count define valid contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_cmd, in_scmd, in_size, in_vadr, in_data, in_rtnctl};
        end
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            mc_rq_vld    <= 1'b0;
            mc_rq_cmd    <= '0;
            mc_rq_scmd   <= '0;
            mc_rq_size   <= '0;
            mc_rq_vadr   <= '0;
            mc_rq_data   <= '0;
            mc_rq_rtnctl <= '0;
            stall_cycles <= '0;
            overflow     <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                {mc_rq_cmd, mc_rq_scmd, mc_rq_size, mc_rq_vadr, mc_rq_data, mc_rq_rtnctl}
                    <= mem[rd_ptr];
            end
            if (push && !pop) begin
                count <= count + (AW+1)'(1);
            end else if (!push && pop) begin
                count <= count - (AW+1)'(1);
            end
            mc_rq_vld <= pop;
            if ((count != '0) && mc_rq_stall && (stall_cycles != 32'hFFFF_FFFF)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (in_vld && full) begin
                overflow <= 1'b1;
            end
        end
    end

    // Flush handshake: drain everything including the output register, then one flush
    // request to the MC, then wait for its completion.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            flush_st    <= StIdle;
            mc_rq_flush <= 1'b0;
            flush_done  <= 1'b0;
        end else begin
            mc_rq_flush <= 1'b0;
            flush_done  <= 1'b0;
            unique case (flush_st)
                StIdle: begin
                    if (in_flush) begin
                        flush_st <= StDrain;
                    end
                end
                StDrain: begin
                    if ((count == '0) && !mc_rq_vld) begin
                        flush_st <= StFlush;
                    end
                end
                StFlush: begin
                    if (!mc_rq_stall) begin
                        mc_rq_flush <= 1'b1;
                        flush_st    <= StWait;
                    end
                end
                StWait: begin
                    if (mc_rs_flush_cmplt) begin
                        flush_done <= 1'b1;
                        flush_st   <= StDone;
                    end
                end
                StDone: begin
                    flush_st <= StIdle;
                end
                default: begin
                    flush_st <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mc_rq_buf.sv
// Scoreboarded bench for mc_rq_buf: directed scenarios followed by random traffic,
// checked against a queue-based reference model of the buffer's behaviour.
module tb_mc_rq_buf;

    localparam int unsigned RW    = 32;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned SLACK = 6;
    localparam int unsigned EW    = 121 + RW;

    logic            clk = 1'b0;
    logic            i_reset = 1'b1;
    logic            in_vld = 1'b0;
    logic [2:0]      in_cmd = '0;
    logic [3:0]      in_scmd = '0;
    logic [1:0]      in_size = '0;
    logic [47:0]     in_vadr = '0;
    logic [63:0]     in_data = '0;
    logic [RW-1:0]   in_rtnctl = '0;
    logic            in_stall;
    logic            in_flush = 1'b0;
    logic            flush_done;
    logic            mc_rq_vld;
    logic [2:0]      mc_rq_cmd;
    logic [3:0]      mc_rq_scmd;
    logic [1:0]      mc_rq_size;
    logic [47:0]     mc_rq_vadr;
    logic [63:0]     mc_rq_data;
    logic [RW-1:0]   mc_rq_rtnctl;
    logic            mc_rq_stall = 1'b0;
    logic            mc_rq_flush;
    logic            mc_rs_flush_cmplt = 1'b0;
    logic [4:0]      occupancy;
    logic [31:0]     stall_cycles;
    logic            overflow;

    mc_rq_buf #(.RTNCTL_WIDTH(RW), .DEPTH(DEPTH), .AF_SLACK(SLACK)) dut (
        .clk               (clk),
        .i_reset           (i_reset),
        .in_vld            (in_vld),
        .in_cmd            (in_cmd),
        .in_scmd           (in_scmd),
        .in_size           (in_size),
        .in_vadr           (in_vadr),
        .in_data           (in_data),
        .in_rtnctl         (in_rtnctl),
        .in_stall          (in_stall),
        .in_flush          (in_flush),
        .flush_done        (flush_done),
        .mc_rq_vld         (mc_rq_vld),
        .mc_rq_cmd         (mc_rq_cmd),
        .mc_rq_scmd        (mc_rq_scmd),
        .mc_rq_size        (mc_rq_size),
        .mc_rq_vadr        (mc_rq_vadr),
        .mc_rq_data        (mc_rq_data),
        .mc_rq_rtnctl      (mc_rq_rtnctl),
        .mc_rq_stall       (mc_rq_stall),
        .mc_rq_flush       (mc_rq_flush),
        .mc_rs_flush_cmplt (mc_rs_flush_cmplt),
        .occupancy         (occupancy),
        .stall_cycles      (stall_cycles),
        .overflow          (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: contents are a queue of expected issues in order.
    logic [EW-1:0] exp_q[$];
    int            m_occ = 0;
    bit            m_vld = 1'b0;
    bit            m_ovf = 1'b0;
    longint        m_stall_cnt = 0;
    int            m_phase = 0;   // 0 idle, 1 drain, 2 flush, 3 wait, 4 done
    bit            m_flush = 1'b0;
    bit            m_done = 1'b0;

    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit do_push;
        bit do_pop;
        if (i_reset) begin
            exp_q.delete();
            m_occ = 0; m_vld = 0; m_ovf = 0; m_stall_cnt = 0;
            m_phase = 0; m_flush = 0; m_done = 0;
            return;
        end
        do_push = in_vld && (m_occ < DEPTH);
        do_pop  = (m_occ > 0) && !mc_rq_stall;
        if (in_vld && m_occ == DEPTH) m_ovf = 1;
        if (m_occ > 0 && mc_rq_stall && m_stall_cnt < 64'hFFFF_FFFF) m_stall_cnt++;
        m_flush = 0;
        m_done  = 0;
        case (m_phase)
            0: if (in_flush) m_phase = 1;
            1: if (m_occ == 0 && !m_vld) m_phase = 2;
            2: if (!mc_rq_stall) begin m_flush = 1; m_phase = 3; end
            3: if (mc_rs_flush_cmplt) begin m_done = 1; m_phase = 4; end
            default: m_phase = 0;
        endcase
        m_vld = do_pop;
        m_occ = m_occ + int'(do_push) - int'(do_pop);
        if (do_push) exp_q.push_back({in_cmd, in_scmd, in_size, in_vadr, in_data, in_rtnctl});
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Monitor: compares DUT state and pops the scoreboard whenever a request is issued.
    initial forever begin
        logic [EW-1:0] exp_e;
        bit exp_stall;
        @(negedge clk);
        exp_stall = ((DEPTH - m_occ) <= SLACK) || (m_phase != 0);
        check("occupancy", EW'(occupancy), EW'(m_occ));
        check("in_stall", EW'(in_stall), EW'(exp_stall));
        check("overflow", EW'(overflow), EW'(m_ovf));
        check("stall_cycles", EW'(stall_cycles), EW'(m_stall_cnt));
        check("mc_rq_vld", EW'(mc_rq_vld), EW'(m_vld));
        check("mc_rq_flush", EW'(mc_rq_flush), EW'(m_flush));
        check("flush_done", EW'(flush_done), EW'(m_done));
        if (mc_rq_vld) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL issue_order: request issued but none expected at %0t", $time);
            end else begin
                exp_e = exp_q.pop_front();
                check("issue_fields",
                      {mc_rq_cmd, mc_rq_scmd, mc_rq_size, mc_rq_vadr, mc_rq_data, mc_rq_rtnctl},
                      exp_e);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rand_req();
        in_vld    = 1'b1;
        in_cmd    = 3'($urandom);
        in_scmd   = 4'($urandom);
        in_size   = 2'($urandom);
        in_vadr   = {16'($urandom), 32'($urandom)};
        in_data   = {32'($urandom), 32'($urandom)};
        in_rtnctl = RW'($urandom);
    endtask

    task automatic push_n(input int n);
        for (int i = 0; i < n; i++) begin
            rand_req();
            tick(1);
        end
        in_vld = 1'b0;
    endtask

    initial begin
        tick(3);
        i_reset = 1'b0;

        // Single request latency from an empty buffer.
        tick(2);
        rand_req();
        in_vadr = 48'h1000;
        tick(1);
        in_vld = 1'b0;
        tick(4);

        // Ten entries under MC stall, then release.
        mc_rq_stall = 1'b1;
        push_n(10);
        tick(4);
        check("af_stall_at_10", EW'(in_stall), EW'(1));
        mc_rq_stall = 1'b0;
        tick(14);

        // Overflow with seventeen pushes into a sixteen-entry buffer.
        mc_rq_stall = 1'b1;
        push_n(17);
        tick(2);
        check("full_occupancy", EW'(occupancy), EW'(DEPTH));
        check("overflow_sticky", EW'(overflow), EW'(1));
        mc_rq_stall = 1'b0;
        tick(20);
        i_reset = 1'b1;
        tick(1);
        i_reset = 1'b0;
        tick(2);

        // Flush with three entries behind an MC stall; stray pulses must be ignored.
        mc_rq_stall = 1'b1;
        push_n(3);
        in_flush = 1'b1;
        tick(1);
        in_flush = 1'b0;
        mc_rs_flush_cmplt = 1'b1;
        in_flush = 1'b1;
        tick(1);
        mc_rs_flush_cmplt = 1'b0;
        in_flush = 1'b0;
        tick(2);
        mc_rq_stall = 1'b0;
        tick(8);
        tick(5);
        mc_rs_flush_cmplt = 1'b1;
        tick(1);
        mc_rs_flush_cmplt = 1'b0;
        tick(4);

        // Continuous push and pop across pointer wrap.
        mc_rq_stall = 1'b1;
        push_n(4);
        mc_rq_stall = 1'b0;
        push_n(40);
        tick(8);

        // Reset during the wait for flush completion with entries buffered.
        in_flush = 1'b1;
        tick(1);
        in_flush = 1'b0;
        tick(5);
        mc_rq_stall = 1'b1;
        push_n(4);
        tick(1);
        i_reset = 1'b1;
        tick(1);
        i_reset = 1'b0;
        mc_rq_stall = 1'b0;
        tick(1);
        mc_rs_flush_cmplt = 1'b1;
        tick(1);
        mc_rs_flush_cmplt = 1'b0;
        tick(4);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            i_reset = ($urandom_range(0, 249) == 0);
            if ($urandom_range(0, 2) != 0) rand_req();
            else in_vld = 1'b0;
            mc_rq_stall       = ($urandom_range(0, 3) == 0) || (i % 100 > 80);
            in_flush          = ($urandom_range(0, 39) == 0);
            mc_rs_flush_cmplt = ($urandom_range(0, 7) == 0);
            tick(1);
        end
        i_reset = 1'b0;
        in_vld = 1'b0;
        in_flush = 1'b0;
        mc_rq_stall = 1'b0;
        mc_rs_flush_cmplt = 1'b0;
        tick(DEPTH + 10);
        check("scoreboard_drained", EW'(exp_q.size()), EW'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_rq_buf.md
MC_RQ_BUF -- requirements
Module: mc_rq_buf

Interface
REQ-001 Parameter RTNCTL_WIDTH, default 32, width of the return-control field.
REQ-002 Parameter DEPTH, default 16, FIFO entries; power of 2, range 8..64.
REQ-003 Parameter AF_SLACK, default 6, free entries remaining at which upstream is stalled.
REQ-004 clk  in  1  single clock, all logic on rising edge.
REQ-005 i_reset  in  1  synchronous, active-high reset.
REQ-006 in_vld, in_cmd[2:0], in_scmd[3:0], in_size[1:0], in_vadr[47:0], in_data[63:0], in_rtnctl[RTNCTL_WIDTH-1:0]  in  request from the PHOLD engine.
REQ-007 in_stall  out  1  almost-full backpressure to the engine.
REQ-008 in_flush  in  1  one-cycle pulse requesting a write flush.
REQ-009 flush_done  out  1  one-cycle pulse when the flush completes.
REQ-010 mc_rq_vld, mc_rq_cmd, mc_rq_scmd, mc_rq_size, mc_rq_vadr, mc_rq_data, mc_rq_rtnctl  out  same widths as REQ-006  request to the MC port.
REQ-011 mc_rq_stall  in  1  MC backpressure.
REQ-012 mc_rq_flush  out  1  flush request to the MC.
REQ-013 mc_rs_flush_cmplt  in  1  MC flush-complete.
REQ-014 occupancy  out  log2(DEPTH)+1  current FIFO entry count.
REQ-015 stall_cycles  out  32  count of cycles spent blocked by the MC.
REQ-016 overflow  out  1  sticky error flag.

Function
REQ-017 The block SHALL push one entry per cycle in which in_vld=1 and occupancy<DEPTH.
REQ-018 When in_vld=1 with occupancy==DEPTH, the block SHALL drop the request and set overflow; overflow SHALL stay set until reset.
REQ-019 in_stall SHALL be combinational and equal 1 when (DEPTH-occupancy)<=AF_SLACK or flush state!=IDLE.
REQ-020 Pop condition: occupancy>0 and mc_rq_stall=0; on a pop the head entry SHALL be registered onto the mc_rq_* outputs with mc_rq_vld=1 on the next cycle.
REQ-021 mc_rq_vld SHALL be 0 in any cycle with no pop in the previous cycle; all mc_rq_* outputs SHALL be registered.
REQ-022 Latency: a request with in_vld at cycle N into an empty FIFO with mc_rq_stall=0 SHALL appear as mc_rq_vld at cycle N+2.
REQ-023 Simultaneous push and pop SHALL leave occupancy unchanged; read/write pointers SHALL wrap modulo DEPTH.
REQ-024 Ordering SHALL be strictly FIFO; field values SHALL pass through unmodified.
REQ-025 stall_cycles SHALL increment in each cycle with occupancy>0 and mc_rq_stall=1, saturating at 0xFFFF_FFFF.
REQ-026 Flush FSM states: IDLE, DRAIN, FLUSH, WAIT, DONE.
REQ-027 IDLE->DRAIN on in_flush=1; in_flush SHALL be ignored in any other state.
REQ-028 DRAIN->FLUSH when occupancy==0 and mc_rq_vld==0; pushes arriving in DRAIN SHALL still be accepted and drained.
REQ-029 In FLUSH, mc_rq_flush SHALL be 1 for exactly one cycle, only when mc_rq_stall=0, then go to WAIT; while mc_rq_stall=1 the FSM SHALL stay in FLUSH with mc_rq_flush=0.
REQ-030 WAIT->DONE on mc_rs_flush_cmplt=1; DONE SHALL assert flush_done for one cycle and return to IDLE.
REQ-031 mc_rs_flush_cmplt outside WAIT SHALL be ignored.

Reset
REQ-032 On i_reset=1 at a clock edge: pointers and occupancy=0, mc_rq_vld=0, mc_rq_flush=0, flush_done=0, stall_cycles=0, overflow=0, FSM=IDLE, all other mc_rq_* fields=0.
REQ-033 Reset mid-operation SHALL discard all buffered entries and any flush in progress; no request SHALL be issued in the cycle after reset.

Verification
REQ-034 Reset, then in_vld for 1 cycle with vadr=0x1000 at cycle 5, mc_rq_stall=0 -> mc_rq_vld=1, mc_rq_vadr=0x1000 at cycle 7 only.
REQ-035 mc_rq_stall=1, push 10 entries with DEPTH=16 -> in_stall=1 once occupancy=10; stall_cycles increments each held cycle; release stall -> 10 entries issued in order, one per cycle.
REQ-036 Hold mc_rq_stall=1 and push 17 entries ignoring in_stall -> occupancy=16, overflow=1, 17th entry never issued.
REQ-037 3 entries buffered, then in_flush with mc_rq_stall=1 for 4 cycles -> mc_rq_flush stays 0 until all 3 are issued and the MC stall is released; mc_rs_flush_cmplt 5 cycles later -> flush_done pulse 1 cycle after it.
REQ-038 Hold push and pop together for 40 cycles with DEPTH=16 -> occupancy constant, pointer wrap-around, data order preserved.
REQ-039 Assert i_reset during WAIT with 4 entries buffered -> next cycle occupancy=0, FSM IDLE, and a late mc_rs_flush_cmplt produces no flush_done.
